// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control / multiply-divide block.
package alu_pkg;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_HI  = 2'b01;
  localparam logic [1:0] RS_LO  = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider on magnitudes with sign fix-up.
// state   | meaning
// MD_IDLE | waiting for start; operands latched on start
// MD_RUN  | one step per cycle, WIDTH steps
// MD_DONE | fixed-up result held in the accumulators for one cycle
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_acc_q, hi_acc_d, lo_acc_q, lo_acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d, a_raw_q, a_raw_d;
  logic             is_div_q, is_div_d, neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d, div0_q, div0_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] step_hi, step_lo, quo_fix, rem_fix, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_fix;

  assign sign_a = is_signed & a[WIDTH-1];
  assign sign_b = is_signed & b[WIDTH-1];
  assign mag_a  = sign_a ? -a : a;
  assign mag_b  = sign_b ? -b : b;

  // Multiply: lo_acc holds the multiplier, shifted out LSB-first under the product.
  assign mul_sum = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: hi_acc is the partial remainder, lo_acc shifts dividend out / quotient in.
  assign rem_sh  = {hi_acc_q, lo_acc_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, opnd_q};
  assign rem_sub = rem_sh - {1'b0, opnd_q};

  assign step_hi = is_div_q ? (rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0])
                            : mul_sum[WIDTH:1];
  assign step_lo = is_div_q ? {lo_acc_q[WIDTH-2:0], rem_ge}
                            : {mul_sum[0], lo_acc_q[WIDTH-1:1]};

  assign prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
  assign quo_fix  = neg_q ? -step_lo : step_lo;
  assign rem_fix  = neg_rem_q ? -step_hi : step_hi;
  assign fix_hi   = is_div_q ? (div0_q ? a_raw_q : rem_fix) : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = is_div_q ? (div0_q ? '1 : quo_fix) : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      hi_acc_q  <= '0;
      lo_acc_q  <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_acc_q  <= hi_acc_d;
      lo_acc_q  <= lo_acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_acc_d  = hi_acc_q;
    lo_acc_d  = lo_acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d   = MD_RUN;
          cnt_d     = '0;
          is_div_d  = is_div;
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          div0_d    = is_div && (b == '0);
          a_raw_d   = a;
          hi_acc_d  = '0;
          lo_acc_d  = is_div ? mag_a : mag_b;
          opnd_d    = is_div ? mag_b : mag_a;
        end
      end
      MD_RUN: begin
        cnt_d    = cnt_q + CW'(1);
        hi_acc_d = step_hi;
        lo_acc_d = step_lo;
        if (cnt_q == LAST) begin
          state_d  = MD_DONE;
          hi_acc_d = fix_hi;
          lo_acc_d = fix_lo;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy   = (state_q == MD_RUN);
  assign done   = (state_q == MD_DONE);
  assign hi_out = hi_acc_q;
  assign lo_out = lo_acc_q;

endmodule

// File: rtl/alu_control_md.sv
// MIPS32 ALU control: funct decode, HI/LO registers and stall for the multi-cycle MD unit.
module alu_control_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             issue,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       op,
  output logic [1:0]       res_sel,
  output logic             stall,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             is_md, is_mthi, is_mtlo;
  logic             md_busy, md_done, md_idle, md_start;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] hi_q, lo_q;

  always_comb begin
    op      = OP_ADD;
    res_sel = RS_ALU;
    illegal = 1'b0;
    is_md   = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    if (alu_op[0]) begin
      op = OP_SUB;
    end else if (alu_op[1]) begin
      case (funct)
        F_ADD:   op = OP_ADD;
        F_SUB:   op = OP_SUB;
        F_AND:   op = OP_AND;
        F_OR:    op = OP_OR;
        F_NOR:   op = OP_NOR;
        F_SLT:   op = OP_SLT;
        F_MFHI:  res_sel = RS_HI;
        F_MFLO:  res_sel = RS_LO;
        F_MTHI:  is_mthi = 1'b1;
        F_MTLO:  is_mtlo = 1'b1;
        F_MULT, F_MULTU, F_DIV, F_DIVU: is_md = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

  assign md_idle  = ~md_busy & ~md_done;
  assign md_start = issue & is_md & md_idle;
  // Gated by rst so a reset mid-operation releases the core immediately.
  assign stall    = issue & is_md & ~md_done & ~rst;

  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .is_div    (funct[1]),
    .is_signed (~funct[0]),
    .a         (rs_val),
    .b         (rt_val),
    .busy      (md_busy),
    .done      (md_done),
    .hi_out    (md_hi),
    .lo_out    (md_lo)
  );

  // The sequencer result is visible during DONE and committed on the way back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_done) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else begin
      if (issue && md_idle && is_mthi) hi_q <= rs_val;
      if (issue && md_idle && is_mtlo) lo_q <= rs_val;
    end
  end

  assign hi = md_done ? md_hi : hi_q;
  assign lo = md_done ? md_lo : lo_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md at WIDTH=32 and WIDTH=8.
module tb_alu_control_md;

  logic        clk, rst;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        issue;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  op;
  logic [1:0]  res_sel;
  logic        stall, illegal;
  logic [31:0] hi, lo;

  logic [1:0]  alu_op8;
  logic [5:0]  funct8;
  logic        issue8;
  logic [7:0]  rs8, rt8;
  logic [3:0]  op8;
  logic [1:0]  res_sel8;
  logic        stall8, illegal8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  alu_control_md #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .issue(issue),
    .rs_val(rs_val), .rt_val(rt_val), .op(op), .res_sel(res_sel),
    .stall(stall), .illegal(illegal), .hi(hi), .lo(lo)
  );

  alu_control_md #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .alu_op(alu_op8), .funct(funct8), .issue(issue8),
    .rs_val(rs8), .rt_val(rt8), .op(op8), .res_sel(res_sel8),
    .stall(stall8), .illegal(illegal8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ao;
    logic [5:0] f;
    logic [3:0] op;
    logic [1:0] rs;
    logic       ill;
  } dvec_t;

  task automatic test_reset();
    rst = 1'b1; alu_op = 2'b10; funct = 6'b011000; issue = 1'b1;
    rs_val = 32'd3; rt_val = 32'd4;
    alu_op8 = 2'b10; funct8 = 6'b011001; issue8 = 1'b0; rs8 = 8'd0; rt8 = 8'd0;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b expected 0", stall); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset lo: got %h expected 0", lo); end
    checks++; if ({hi8, lo8} !== 16'h0) begin errors++; $display("FAIL reset w8 hilo: got %h expected 0", {hi8, lo8}); end
    issue = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode();
    dvec_t v;
    dvec_t vecs [14];
    vecs[0]  = '{2'b00, 6'b000000, 4'b0010, 2'b00, 1'b0};
    vecs[1]  = '{2'b01, 6'b100000, 4'b0110, 2'b00, 1'b0};
    vecs[2]  = '{2'b11, 6'b111111, 4'b0110, 2'b00, 1'b0};
    vecs[3]  = '{2'b10, 6'b100000, 4'b0010, 2'b00, 1'b0};
    vecs[4]  = '{2'b10, 6'b100010, 4'b0110, 2'b00, 1'b0};
    vecs[5]  = '{2'b10, 6'b100100, 4'b0000, 2'b00, 1'b0};
    vecs[6]  = '{2'b10, 6'b100101, 4'b0001, 2'b00, 1'b0};
    vecs[7]  = '{2'b10, 6'b100111, 4'b1100, 2'b00, 1'b0};
    vecs[8]  = '{2'b10, 6'b101010, 4'b0111, 2'b00, 1'b0};
    vecs[9]  = '{2'b10, 6'b111111, 4'b0010, 2'b00, 1'b1};
    vecs[10] = '{2'b10, 6'b010000, 4'b0010, 2'b01, 1'b0};
    vecs[11] = '{2'b10, 6'b010010, 4'b0010, 2'b10, 1'b0};
    vecs[12] = '{2'b10, 6'b011000, 4'b0010, 2'b00, 1'b0};
    vecs[13] = '{2'b10, 6'b010011, 4'b0010, 2'b00, 1'b0};
    issue = 1'b0;
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      alu_op = v.ao; funct = v.f;
      #1;
      checks++; if (op !== v.op) begin errors++; $display("FAIL decode[%0d] op: got %b expected %b", i, op, v.op); end
      checks++; if (res_sel !== v.rs) begin errors++; $display("FAIL decode[%0d] res_sel: got %b expected %b", i, res_sel, v.rs); end
      checks++; if (illegal !== v.ill) begin errors++; $display("FAIL decode[%0d] illegal: got %b expected %b", i, illegal, v.ill); end
    end
  endtask

  // Called just after a negedge; returns just after the negedge of the DONE cycle.
  task automatic md_run(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_stall);
    int n;
    bit seen;
    alu_op = 2'b10; funct = f; rs_val = a; rt_val = b; issue = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!stall) begin seen = 1'b1; break; end
      n++;
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL %s timeout: stall still 1 after %0d cycles", name, n); end
    checks++; if (n != exp_stall) begin errors++; $display("FAIL %s stall cycles: got %0d expected %0d", name, n, exp_stall); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo); end
  endtask

  task automatic test_mult();
    @(negedge clk);
    md_run("mult -3x7", 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
    @(negedge clk);
    funct = 6'b010000;
    #1;
    checks++; if (res_sel !== 2'b01) begin errors++; $display("FAIL mfhi res_sel: got %b expected 01", res_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mfhi stall: got %b expected 0", stall); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mfhi hi: got %h expected ffffffff", hi); end
    funct = 6'b010010;
    #1;
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mflo lo: got %h expected ffffffeb", lo); end
    issue = 1'b0;
  endtask

  task automatic test_back_to_back_div();
    @(negedge clk);
    md_run("divu 100/7", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    @(negedge clk);
    md_run("div -7/2", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    issue = 1'b0;
  endtask

  task automatic test_corner_div();
    @(negedge clk);
    md_run("divu 5/0", 6'b011011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33);
    @(negedge clk);
    md_run("div min/-1", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
    @(negedge clk);
    md_run("div -5/0", 6'b011010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 33);
    issue = 1'b0;
  endtask

  task automatic test_mt();
    @(negedge clk);
    alu_op = 2'b10; funct = 6'b010011; rs_val = 32'hDEADBEEF; issue = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mtlo stall: got %b expected 0", stall); end
    @(negedge clk);
    funct = 6'b010010;
    #1;
    checks++; if (lo !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo->mflo lo: got %h expected deadbeef", lo); end
    checks++; if (res_sel !== 2'b10) begin errors++; $display("FAIL mflo res_sel: got %b expected 10", res_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mflo stall: got %b expected 0", stall); end
    issue = 1'b0;
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    alu_op = 2'b10; funct = 6'b011001; rs_val = 32'h00010000; rt_val = 32'h00010000; issue = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrun reset stall: got %b expected 0", stall); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midrun reset hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midrun reset lo: got %h expected 0", lo); end
    @(negedge clk);
    rst = 1'b0;
    md_run("multu after reset", 6'b011001, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 33);
    issue = 1'b0;
  endtask

  task automatic test_mt_drop();
    @(negedge clk);
    alu_op = 2'b10; funct = 6'b011001; rs_val = 32'd3; rt_val = 32'd5; issue = 1'b1;
    repeat (2) @(negedge clk);
    funct = 6'b010001; rs_val = 32'h1234;
    repeat (2) @(negedge clk);
    issue = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mt drop hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'd15) begin errors++; $display("FAIL mt drop lo: got %h expected f", lo); end
  endtask

  task automatic md_run8(input string name, input logic [5:0] f, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
    int n;
    bit seen;
    alu_op8 = 2'b10; funct8 = f; rs8 = a; rt8 = b; issue8 = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall8) begin seen = 1'b1; break; end
      n++;
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL %s timeout: stall still 1 after %0d cycles", name, n); end
    checks++; if (n != 9) begin errors++; $display("FAIL %s stall cycles: got %0d expected 9", name, n); end
    checks++; if (hi8 !== exp_hi) begin errors++; $display("FAIL %s hi: got %h expected %h", name, hi8, exp_hi); end
    checks++; if (lo8 !== exp_lo) begin errors++; $display("FAIL %s lo: got %h expected %h", name, lo8, exp_lo); end
  endtask

  task automatic test_width8();
    @(negedge clk);
    md_run8("w8 multu ffxff", 6'b011001, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    @(negedge clk);
    md_run8("w8 mult -1x2", 6'b011000, 8'hFF, 8'h02, 8'hFF, 8'hFE);
    issue8 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_back_to_back_div();
    test_corner_div();
    test_mt();
    test_reset_midrun();
    test_mt_drop();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
